echo_measure_sequencer: RTL and testbench

//  Top-level scheduler for one ultrasonic ranging period. Generates the 10 ms measurement tick
//  and clears the sample FIFO. Issues sys_start_pulse to the correlator and drives the 90 kHz

---
 rtl/echo_measure_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_echo_measure_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_measure_sequencer.sv
// Ranging-period scheduler: 10 ms tick, FIFO clear, correlator start, 90 kHz TX burst,
// ADC write gating, and a valid/ready result port fed by proc_done or a timeout.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for the period tick
// S_CLEAR     | FIFO clear; sys_start_pulse in the last cycle
// S_TX        | complementary burst on tx_p/tx_n, ADC writes enabled
// S_WAIT_DONE | burst over, waiting for proc_done or timeout
// S_REPORT    | result held on res_* until res_ready
`timescale 1ns/1ps
module echo_measure_sequencer #(
  parameter int PERIOD_CYCLES  = 500000,
  parameter int TX_PULSES      = 8,
  parameter int TX_HALF_CYCLES = 278,
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        enable,
  output logic        fifo_clr,
  output logic        sys_start_pulse,
  output logic        adc_wr_en,
  output logic        tx_p,
  output logic        tx_n,
  input  logic        proc_done,
  input  logic        hit_flag,
  input  logic [19:0] echo_tof,
  input  logic [17:0] echo_peak,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_hit,
  output logic [19:0] res_tof,
  output logic [17:0] res_peak,
  output logic        res_timeout,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int TX_CYCLES = 2 * TX_PULSES * TX_HALF_CYCLES;
  localparam int SEQ_MAX   = (TX_CYCLES > CLR_CYCLES) ? TX_CYCLES : CLR_CYCLES;
  localparam int PW        = $clog2(PERIOD_CYCLES + 1);
  localparam int SW        = $clog2(SEQ_MAX + 1);
  localparam int HW        = $clog2(TX_HALF_CYCLES + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_TX        = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] period_cnt;
  logic [SW-1:0] seq_cnt, seq_d;
  logic [HW-1:0] half_cnt, half_d;
  logic [TW-1:0] to_cnt, to_d;
  logic          phase, phase_d;
  logic          tick;

  logic        fifo_clr_d, sys_start_d, adc_wr_en_d, tx_p_d, tx_n_d;
  logic        res_valid_d, busy_d, res_hit_d, res_timeout_d;
  logic [19:0] res_tof_d;
  logic [17:0] res_peak_d;

  assign tick = enable && (period_cnt == '0);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (!enable || period_cnt == PW'(PERIOD_CYCLES - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // State, sequencing counters and all outputs are registered together.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      seq_cnt         <= '0;
      half_cnt        <= '0;
      to_cnt          <= '0;
      phase           <= 1'b0;
      fifo_clr        <= 1'b0;
      sys_start_pulse <= 1'b0;
      adc_wr_en       <= 1'b0;
      tx_p            <= 1'b0;
      tx_n            <= 1'b0;
      res_valid       <= 1'b0;
      res_hit         <= 1'b0;
      res_tof         <= '0;
      res_peak        <= '0;
      res_timeout     <= 1'b0;
      busy            <= 1'b0;
      overrun_cnt     <= '0;
    end else begin
      state           <= state_d;
      seq_cnt         <= seq_d;
      half_cnt        <= half_d;
      to_cnt          <= to_d;
      phase           <= phase_d;
      fifo_clr        <= fifo_clr_d;
      sys_start_pulse <= sys_start_d;
      adc_wr_en       <= adc_wr_en_d;
      tx_p            <= tx_p_d;
      tx_n            <= tx_n_d;
      res_valid       <= res_valid_d;
      res_hit         <= res_hit_d;
      res_tof         <= res_tof_d;
      res_peak        <= res_peak_d;
      res_timeout     <= res_timeout_d;
      busy            <= busy_d;
      if (tick && state != S_IDLE && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state;
    seq_d   = seq_cnt;
    half_d  = half_cnt;
    to_d    = to_cnt;
    phase_d = phase;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_d = S_CLEAR;
          seq_d   = SW'(CLR_CYCLES - 1);
        end
      end
      S_CLEAR: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (seq_cnt == '0) begin
          state_d = S_TX;
          seq_d   = SW'(TX_CYCLES - 1);
          half_d  = HW'(TX_HALF_CYCLES - 1);
          phase_d = 1'b1;
          to_d    = '0;
        end else begin
          seq_d = seq_cnt - SW'(1);
        end
      end
      S_TX: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_cnt + TW'(1);
          if (seq_cnt == '0) begin
            state_d = S_WAIT_DONE;
          end else begin
            seq_d = seq_cnt - SW'(1);
            if (half_cnt == '0) begin
              half_d  = HW'(TX_HALF_CYCLES - 1);
              phase_d = ~phase;
            end else begin
              half_d = half_cnt - HW'(1);
            end
          end
        end
      end
      S_WAIT_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_cnt + TW'(1);
          if (proc_done || to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with it after the edge.
  always_comb begin
    fifo_clr_d    = (state_d == S_CLEAR);
    sys_start_d   = (state_d == S_CLEAR) && (seq_d == '0);
    tx_p_d        = (state_d == S_TX) && phase_d;
    tx_n_d        = (state_d == S_TX) && !phase_d;
    adc_wr_en_d   = (state_d == S_TX) || (state_d == S_WAIT_DONE);
    res_valid_d   = (state_d == S_REPORT);
    busy_d        = (state_d != S_IDLE);
    res_hit_d     = res_hit;
    res_tof_d     = res_tof;
    res_peak_d    = res_peak;
    res_timeout_d = res_timeout;
    if (state == S_WAIT_DONE && state_d == S_REPORT) begin
      if (proc_done) begin
        res_hit_d     = hit_flag;
        res_tof_d     = echo_tof;
        res_peak_d    = echo_peak;
        res_timeout_d = 1'b0;
      end else begin
        res_hit_d     = 1'b0;
        res_tof_d     = '0;
        res_peak_d    = '0;
        res_timeout_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_measure_sequencer.sv
// Directed bench for echo_measure_sequencer with a short period and burst so every
// phase boundary can be checked against hand-computed cycle offsets.
`timescale 1ns/1ps
module tb_echo_measure_sequencer;
  localparam int PERIOD = 200;
  localparam int PULSES = 2;
  localparam int HALF   = 4;
  localparam int CLR    = 4;
  localparam int TMO    = 100;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        proc_done = 1'b0;
  logic        hit_flag = 1'b0;
  logic [19:0] echo_tof = '0;
  logic [17:0] echo_peak = '0;
  logic        res_ready = 1'b0;
  logic        fifo_clr, sys_start_pulse, adc_wr_en, tx_p, tx_n;
  logic        res_valid, res_hit, res_timeout, busy;
  logic [19:0] res_tof;
  logic [17:0] res_peak;
  logic [7:0]  overrun_cnt;
  logic [54:0] outs_vec;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  echo_measure_sequencer #(
    .PERIOD_CYCLES(PERIOD), .TX_PULSES(PULSES), .TX_HALF_CYCLES(HALF),
    .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .enable(enable),
    .fifo_clr(fifo_clr), .sys_start_pulse(sys_start_pulse), .adc_wr_en(adc_wr_en),
    .tx_p(tx_p), .tx_n(tx_n), .proc_done(proc_done), .hit_flag(hit_flag),
    .echo_tof(echo_tof), .echo_peak(echo_peak), .res_valid(res_valid),
    .res_ready(res_ready), .res_hit(res_hit), .res_tof(res_tof), .res_peak(res_peak),
    .res_timeout(res_timeout), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  assign outs_vec = {fifo_clr, sys_start_pulse, adc_wr_en, tx_p, tx_n, res_valid, res_hit,
                     res_tof, res_peak, res_timeout, busy, overrun_cnt};

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return fifo_clr;
      1:       return sys_start_pulse;
      2:       return tx_p;
      default: return res_valid;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int budget, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_50M);
      if (pick(which)) begin
        found = 1'b1;
        at = cyc;
      end
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  initial begin
    int e0, at, tx0, n, last, badint;
    logic sticky;
    logic [20:0] clr_v, st_v, txp_v, txn_v, adc_v;
    logic [20:0] exp_clr, exp_st, exp_txp, exp_txn, exp_adc;

    // 1: reset and idle with enable low
    repeat (3) @(negedge clk_50M);
    chk("reset_outs", 64'(outs_vec), 64'd0);
    rst_n = 1'b1;
    sticky = 1'b0;
    repeat (2000) begin
      @(negedge clk_50M);
      sticky |= (outs_vec != '0);
    end
    chk("idle_quiet", 64'(sticky), 64'd0);

    // 2: one full measurement with proc_done
    enable = 1'b1;
    res_ready = 1'b1;
    clr_v = '0; st_v = '0; txp_v = '0; txn_v = '0; adc_v = '0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk_50M);
      if (i == 0) e0 = cyc;
      clr_v = {clr_v[19:0], fifo_clr};
      st_v  = {st_v[19:0], sys_start_pulse};
      txp_v = {txp_v[19:0], tx_p};
      txn_v = {txn_v[19:0], tx_n};
      adc_v = {adc_v[19:0], adc_wr_en};
    end
    exp_clr = {4'b1111, 17'b0};
    exp_st  = {3'b000, 1'b1, 17'b0};
    exp_txp = {4'b0, 16'b1111000011110000, 1'b0};
    exp_txn = {4'b0, 16'b0000111100001111, 1'b0};
    exp_adc = {4'b0, 17'h1FFFF};
    chk("clr_pattern", 64'(clr_v), 64'(exp_clr));
    chk("start_pattern", 64'(st_v), 64'(exp_st));
    chk("txp_pattern", 64'(txp_v), 64'(exp_txp));
    chk("txn_pattern", 64'(txn_v), 64'(exp_txn));
    chk("adc_pattern", 64'(adc_v), 64'(exp_adc));
    chk("busy_wait", 64'(busy), 64'd1);
    proc_done = 1'b1; hit_flag = 1'b1; echo_tof = 20'd1234; echo_peak = 18'd5000;
    @(negedge clk_50M);
    proc_done = 1'b0;
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_hit", 64'(res_hit), 64'd1);
    chk("res_tof", 64'(res_tof), 64'd1234);
    chk("res_peak", 64'(res_peak), 64'd5000);
    chk("res_timeout0", 64'(res_timeout), 64'd0);
    chk("adc_off_report", 64'(adc_wr_en), 64'd0);
    @(negedge clk_50M);
    chk("valid_drop", 64'(res_valid), 64'd0);
    chk("busy_drop", 64'(busy), 64'd0);
    chk("tof_retained", 64'(res_tof), 64'd1234);

    // 3: backpressure across a tick
    res_ready = 1'b0;
    wait_for("wait_start2", 1, 250, at);
    chk("start2_time", 64'(at - e0), 64'd203);
    repeat (17) @(negedge clk_50M);
    proc_done = 1'b1; hit_flag = 1'b0; echo_tof = 20'd777; echo_peak = 18'd321;
    @(negedge clk_50M);
    proc_done = 1'b0;
    chk("bp_valid", 64'(res_valid), 64'd1);
    chk("bp_tof", 64'(res_tof), 64'd777);
    sticky = 1'b0;
    repeat (185) begin
      @(negedge clk_50M);
      sticky |= (res_valid !== 1'b1) || (res_tof != 20'd777) || (res_peak != 18'd321)
               || (res_hit != 1'b0) || fifo_clr;
    end
    chk("bp_stable", 64'(sticky), 64'd0);
    chk("overrun_one", 64'(overrun_cnt), 64'd1);
    res_ready = 1'b1;
    @(negedge clk_50M);
    chk("bp_release", 64'(res_valid), 64'd0);
    wait_for("wait_clr3", 0, 250, at);
    chk("next_tick_time", 64'(at - e0), 64'd600);

    // 4: timeout with proc_done never asserted
    wait_for("wait_tx4", 2, 10, tx0);
    chk("tx4_time", 64'(tx0 - e0), 64'd604);
    wait_for("wait_to", 3, 150, at);
    chk("timeout_latency", 64'(at - tx0), 64'd100);
    chk("to_flag", 64'(res_timeout), 64'd1);
    chk("to_hit", 64'(res_hit), 64'd0);
    chk("to_tof", 64'(res_tof), 64'd0);
    chk("to_peak", 64'(res_peak), 64'd0);

    // 5: enable dropped mid-TX
    wait_for("wait_tx5", 2, 250, at);
    repeat (5) @(negedge clk_50M);
    enable = 1'b0;
    @(negedge clk_50M);
    chk("abort_tx", 64'({tx_p, tx_n, adc_wr_en}), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    sticky = 1'b0;
    repeat (60) begin
      @(negedge clk_50M);
      sticky |= res_valid | fifo_clr | busy | tx_p;
    end
    chk("abort_quiet", 64'(sticky), 64'd0);

    // async reset in the middle of a burst
    enable = 1'b1;
    wait_for("wait_tx_rst", 2, 20, at);
    repeat (3) @(negedge clk_50M);
    chk("pre_rst_adc", 64'(adc_wr_en), 64'd1);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 64'(outs_vec), 64'd0);
    @(negedge clk_50M);
    enable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_50M);

    // 6: periodic operation, 20 periods
    proc_done = 1'b1;
    res_ready = 1'b1;
    enable = 1'b1;
    n = 0; last = 0; badint = 0;
    for (int i = 0; i < 20 * PERIOD + 50 && n < 20; i++) begin
      @(negedge clk_50M);
      if (sys_start_pulse) begin
        if (n > 0 && (cyc - last) != PERIOD) badint++;
        last = cyc;
        n++;
      end
    end
    chk("periodic_count", 64'(n), 64'd20);
    chk("periodic_interval", 64'(badint), 64'd0);
    chk("periodic_overrun", 64'(overrun_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
